// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the arbitrated output multiplexer and its priority picker.
package rr_arbiter_pkg;

  localparam int NBITS_DEF = 32;
  localparam int NCHAN_DEF = 4;

  // Index width that never collapses to zero bits, even for a two-channel arbiter.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational request picker: round-robin after 'last', or fixed lowest-index priority.
module rr_priority_picker
  import rr_arbiter_pkg::*;
#(
  parameter int NCHAN       = NCHAN_DEF,
  parameter int ROUND_ROBIN = 1,
  localparam int CW         = clog2w(NCHAN)
) (
  input  logic [NCHAN-1:0] req,
  input  logic [CW-1:0]    last,
  output logic [NCHAN-1:0] grant,
  output logic [CW-1:0]    grant_idx,
  output logic             any_grant
);

  int start;
  int idx;

  // Scan upward from the start point with wrap-around; the first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    start     = (ROUND_ROBIN != 0) ? (int'(last) + 1) % NCHAN : 0;
    for (int k = 0; k < NCHAN; k++) begin
      idx = (start + k) % NCHAN;
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant_idx  = CW'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_mux.sv
// N-to-1 arbitrated mux with one registered output word and valid/ready on every channel.
module rr_arbiter_mux
  import rr_arbiter_pkg::*;
#(
  parameter int NBITS       = NBITS_DEF,
  parameter int NCHAN       = NCHAN_DEF,
  parameter int ROUND_ROBIN = 1,
  localparam int CW         = clog2w(NCHAN)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCHAN-1:0]       req_valid,
  input  logic [NCHAN*NBITS-1:0] req_data,
  output logic [NCHAN-1:0]       req_ready,
  output logic                   out_valid,
  output logic [NBITS-1:0]       out_data,
  output logic [CW-1:0]          out_channel,
  input  logic                   out_ready
);

  logic [NCHAN-1:0] grant;
  logic [CW-1:0]    grant_idx;
  logic             any_grant;
  logic [CW-1:0]    last;
  logic             can_load;
  logic             take;
  logic [NBITS-1:0] sel_data;

  rr_priority_picker #(
    .NCHAN       (NCHAN),
    .ROUND_ROBIN (ROUND_ROBIN)
  ) picker (
    .req       (req_valid),
    .last      (last),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Accepting is gated by reset so no producer sees a handshake while the block is held in reset.
  assign can_load  = !out_valid || out_ready;
  assign take      = any_grant && can_load && reset;
  assign req_ready = take ? grant : '0;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (grant[i]) sel_data = req_data[i*NBITS +: NBITS];
    end
  end

  // A load on the same edge as a drain simply replaces the word, giving full throughput.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_channel <= '0;
      last        <= CW'(NCHAN - 1);
    end else if (take) begin
      out_valid   <= 1'b1;
      out_data    <= sel_data;
      out_channel <= grant_idx;
      last        <= grant_idx;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
